// File: rtl/music_seq.sv
// Song sequencer: steps an address through one of NUM_SONGS synchronous note
// ROMs and presents each note word to the note player.
// Latency: start -> first note_valid is ROM_LAT+2 cycles; next -> next note_valid is ROM_LAT+2 cycles.
// Backpressure: note_valid/note_data hold until next; no ROM fetch while a note waits.
// Ports: clk/rst_n; start/stop/loop_en/sel control; next from the note player;
//        rom_en/rom_addr/rom_data to the song ROMs; note_data/note_valid,
//        busy, song_done, cur_song status.
module music_seq #(
   parameter int                    NUM_SONGS  = 4,
   parameter int                    SEL_W      = 2,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] END_CODE   = '0,
   parameter int                    ROM_LAT    = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            stop,
   input  logic                            loop_en,
   input  logic [SEL_W-1:0]                sel,
   input  logic                            next,
   output logic [NUM_SONGS-1:0]            rom_en,
   output logic [ADDR_WIDTH-1:0]           rom_addr,
   input  logic [NUM_SONGS*DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0]           note_data,
   output logic                            note_valid,
   output logic                            busy,
   output logic                            song_done,
   output logic [SEL_W-1:0]                cur_song
);

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

   // Wait counter covers ROM_LAT up to 4.
   localparam int CNT_W = 3;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
   logic [CNT_W-1:0]        wait_cnt, wait_nxt;
   logic [SEL_W-1:0]        song_nxt;
   logic [DATA_WIDTH-1:0]   note_nxt;
   logic                    valid_nxt;
   logic                    done_nxt;
   logic                    song_end;
   logic                    sel_ok;
   logic [DATA_WIDTH-1:0]   rom_word;

   assign sel_ok   = ({{(32-SEL_W){1'b0}}, sel} < 32'(NUM_SONGS));
   assign rom_addr = addr;
   assign busy     = (state != IDLE);

   // Slice mux over existing songs only; cur_song is never latched out of range.
   always_comb begin
      rom_word = '0;
      for (int i = 0; i < NUM_SONGS; i++) begin
         if (cur_song == SEL_W'(i)) rom_word = rom_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      rom_en = '0;
      for (int i = 0; i < NUM_SONGS; i++) begin
         rom_en[i] = (state == FETCH) && (cur_song == SEL_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr       <= '0;
         wait_cnt   <= '0;
         cur_song   <= '0;
         note_data  <= '0;
         note_valid <= 1'b0;
         song_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr       <= addr_nxt;
         wait_cnt   <= wait_nxt;
         cur_song   <= song_nxt;
         note_data  <= note_nxt;
         note_valid <= valid_nxt;
         song_done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      wait_nxt  = wait_cnt;
      song_nxt  = cur_song;
      note_nxt  = note_data;
      valid_nxt = note_valid;
      done_nxt  = 1'b0;
      song_end  = 1'b0;

      if (stop) begin
         // Abort: no song_done, cur_song retained for status.
         state_nxt = IDLE;
         valid_nxt = 1'b0;
         wait_nxt  = '0;
      end else if (start && sel_ok) begin
         // Start from any state restarts the selected song at address 0.
         state_nxt = FETCH;
         song_nxt  = sel;
         addr_nxt  = '0;
         wait_nxt  = '0;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            FETCH: begin
               // Final FETCH cycle: ROM output for addr is valid now.
               if (wait_cnt == CNT_W'(ROM_LAT)) begin
                  wait_nxt = '0;
                  if (rom_word != END_CODE) begin
                     note_nxt  = rom_word;
                     valid_nxt = 1'b1;
                     state_nxt = PRESENT;
                  end else begin
                     song_end = 1'b1;
                  end
               end else begin
                  wait_nxt = wait_cnt + CNT_W'(1);
               end
            end
            PRESENT: begin
               if (next) begin
                  valid_nxt = 1'b0;
                  if (addr != '1) begin
                     addr_nxt  = addr + ADDR_WIDTH'(1);
                     state_nxt = FETCH;
                  end else begin
                     // Address space exhausted: same as an end marker.
                     song_end = 1'b1;
                  end
               end
            end
            IDLE:    ;
            default: state_nxt = IDLE;
         endcase

         if (song_end) begin
            done_nxt  = 1'b1;
            addr_nxt  = '0;
            wait_nxt  = '0;
            state_nxt = loop_en ? FETCH : IDLE;
         end
      end
   end

endmodule

// File: doc/music_seq.md
Name: music_seq

Overview:
- Parametrised song sequencer for the buzzer music path. It steps an address counter through one of NUM_SONGS synchronous note ROMs and presents each note word to the note player with a valid/next handshake.
- END_CODE is the end-of-song marker. On the end marker the block stops or loops, and pulses song_done.
- It supersedes the fixed 4-song free-running counter with per-note flow control, explicit start/stop, loop mode and configurable ROM read latency.

Parameters:
- NUM_SONGS, 4: number of song ROMs attached (2..16).
- SEL_W, 2: width of sel; must satisfy 2^SEL_W >= NUM_SONGS.
- ADDR_WIDTH, 16: ROM address width.
- DATA_WIDTH, 12: note word width.
- END_CODE, 0: note word value that marks end of song.
- ROM_LAT, 1: ROM read latency in cycles (1..4).

Ports:
- clk, input, 1: system clock. All logic runs on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin playing song sel.
- stop, input, 1: one-cycle request to abort playback.
- loop_en, input, 1: when 1, the song restarts at address 0 on its end marker.
- sel, input, SEL_W: song index, sampled only when start is accepted.
- next, input, 1: note player has consumed the current note.
- rom_en, output, NUM_SONGS: one-hot ROM enable.
- rom_addr, output, ADDR_WIDTH: ROM address, shared by all ROMs.
- rom_data, input, NUM_SONGS*DATA_WIDTH: concatenated ROM outputs; song i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- note_data, output, DATA_WIDTH: current note word.
- note_valid, output, 1: note_data is valid.
- busy, output, 1: high whenever the state is not IDLE.
- song_done, output, 1: one-cycle pulse when a song end is reached.
- cur_song, output, SEL_W: index of the song being played.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. This includes addr, the wait counter, rom_en, note_data, note_valid, busy, song_done and cur_song. Reset mid-song aborts immediately with no song_done.
- States: IDLE, FETCH, PRESENT.
- IDLE:
  - A start with sel < NUM_SONGS latches cur_song=sel and addr=0, then the state moves to FETCH.
  - A start with sel >= NUM_SONGS is ignored; the state stays IDLE.
- FETCH:
  - rom_en[cur_song]=1 and all other bits are 0. rom_addr=addr is held stable.
  - The state lasts exactly ROM_LAT+1 cycles, counted by the wait counter.
  - rom_data slice cur_song is sampled at the edge ending the final FETCH cycle.
  - Sampled word != END_CODE: note_data=word, note_valid=1, next state PRESENT.
  - Sampled word == END_CODE: song_done pulses 1 in the following cycle and note_valid stays 0.
    - loop_en=1: addr=0, re-enter FETCH.
    - loop_en=0: go to IDLE.
- PRESENT:
  - note_valid and note_data are held until next=1.
  - On next, the state advances, clearing note_valid to 0 on the same edge.
  - If addr != all-ones: addr=addr+1, go to FETCH.
  - If addr == all-ones (address wrap): treat as end of song, with the same song_done/loop_en handling as END_CODE. The address wraps to 0.
  - next outside PRESENT is ignored.
- rom_en is 0 in IDLE and PRESENT.
- Latency with ROM_LAT=1: start sampled at edge E0; FETCH occupies cycles 1–2; note_valid=1 from cycle 3.
  - Each next-to-note_valid turnaround is ROM_LAT+2 cycles.
- Priority: rst_n > stop > start > normal sequencing.
  - stop in any state: next state IDLE, note_valid=0, rom_en=0, no song_done. cur_song keeps its last value.
  - start while busy (and no stop): restart immediately. The new sel is latched, addr=0, state FETCH, note_valid cleared, no song_done for the aborted song.
  - stop and start in the same cycle: stop wins and start is dropped.
- loop_en is sampled at the end-detection edge only. Changing it mid-song has no effect until the end is reached.
- Width rules:
  - addr increments modulo 2^ADDR_WIDTH.
  - cur_song indexes the rom_data slices; no out-of-range slice is ever selected.

Test Plan:
- Basic play: ROM_LAT=1, song 2 = {0x123, 0x456, 0x000}, start with sel=2, next pulsed 2 cycles after each note_valid.
  - Response: notes 0x123 then 0x456; note_valid first high 3 cycles after the start edge; rom_en=4'b0100 only during FETCH.
  - Then song_done is a single 1-cycle pulse after address 2, and the block returns to IDLE with busy=0.
- Flow control: hold next=0 for 20 cycles on note 0x123.
  - Response: note_valid=1 and note_data=0x123 stay stable, rom_addr stays 0, and rom_en=0 throughout.
- Loop: same ROM with loop_en=1, and next asserted continuously.
  - Response: sequence 0x123, 0x456, song_done, 0x123, ...
  - busy stays 1 and rom_addr returns to 0 after the end marker.
- Abort/restart and stop precedence:
  - stop during note 2: IDLE next cycle, no song_done.
  - start sel=1 while busy: cur_song=1, first note from song 1 address 0.
  - stop and start in the same cycle: block ends in IDLE.
  - start with sel=5 and NUM_SONGS=4: ignored.
- Latency and wrap: ROM_LAT=3, ADDR_WIDTH=4, song with no END_CODE (all 0x001).
  - Response: FETCH lasts 4 cycles.
  - After address 15 is consumed, song_done pulses, the block enters IDLE, and addr wraps to 0.
- Async reset: deassert rst_n mid-FETCH, between clock edges.
  - Response: all outputs are 0 immediately with no clock, and the block is in IDLE after release.
